mem_ctrl: RTL and testbench

Memory controller that shares the single byte-wide RAM port between instruction fetch (IF) and the load/store buffer (LSB). It arbitrates between the two requesters, splits each 1/2/4-byte access into sequential byte cycles, and reassembles and sign/zero-extends read data. It returns one-cycle completion pulses to the requester.

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_ctrl_if.sv | 53 +++++
 rtl/mem_ctrl_extend.sv | 23 ++
 rtl/mem_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller slice.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    // Who won the most recent contested arbitration.
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_LSB = 1'b1
    } grant_t;

    localparam logic [1:0] SZ_B  = 2'd0;
    localparam logic [1:0] SZ_H  = 2'd1;
    localparam logic [1:0] SZ_W  = 2'd3;

    // addr[17:16] of the memory-mapped I/O region (0x30000 and up).
    localparam logic [1:0] IO_HI = 2'b11;

    // Number of byte cycles for a size code; the unused code 2 is a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the IF, LSB and RAM-side signals of the memory controller.
// Latency: none (wires only).
// Backpressure: lsb_enable gates LSB strobes; if_req is a level held until if_done.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    // instruction fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              if_flush;

    // load/store buffer side
    logic              lsb_flag;
    logic              lsb_r_nw;
    logic              load_sign;
    logic [1:0]        data_size_to_mc;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_write;
    logic              lsb_enable;
    logic              data_rdy;
    logic [31:0]       data_read;
    logic              lsb_flush;

    // RAM / IO side
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    // controller view
    modport slave (
        input  if_req, if_addr, if_flush,
        input  lsb_flag, lsb_r_nw, load_sign, data_size_to_mc, data_addr, data_write, lsb_flush,
        input  mem_din, io_buffer_full,
        output if_done, if_inst,
        output lsb_enable, data_rdy, data_read,
        output mem_dout, mem_a, mem_wr
    );

    // requester / RAM view
    modport master (
        output if_req, if_addr, if_flush,
        output lsb_flag, lsb_r_nw, load_sign, data_size_to_mc, data_addr, data_write, lsb_flush,
        output mem_din, io_buffer_full,
        input  if_done, if_inst,
        input  lsb_enable, data_rdy, data_read,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_extend.sv
// Assembles the four captured bytes and sign/zero-extends byte and half loads.
// Latency: combinational.
// Backpressure: none.
module mc_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ext
);

    // Keep the low byte/half and fill upward with its sign bit or zeros.
    always_comb begin
        ext = word;
        case (size)
            SZ_B:    ext = {{24{sign & word[7]}}, word[7:0]};
            SZ_H:    ext = {{16{sign & word[15]}}, word[15:0]};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between IF and LSB; splits accesses into byte cycles. Optional macro: MC_IO_STALL_EN.
// Latency: N-byte read pulses in c0+N+1 (word load 6 cycles after acceptance); N-byte write pulses in c0+N.
// Backpressure: rdy=0 freezes state; LSB accepted only while lsb_enable; I/O writes hold while io_buffer_full (macro).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              data_rdy_q, data_rdy_d;
    logic [31:0]       data_read_q, data_read_d;

    logic              rdy_stall;
    logic              lsb_en;
    logic              lsb_go;
    logic              if_go;
    logic              rd_state;
    logic              flush_own;
    logic              io_stall;
    logic [31:0]       cur_word;
    logic [31:0]       ext_word;
    logic [7:0]        wr_byte;

    assign rdy_stall = !rdy || rst;
    assign lsb_en    = (state_q == IDLE) && !rdy_stall;
    assign lsb_go    = bus.lsb_flag && lsb_en;
    // if_req is still high during its own done pulse, and a fetch being
    // flushed must not be restarted from the stale address.
    assign if_go     = bus.if_req && !if_done_q && !bus.if_flush;
    assign rd_state  = (state_q == IF_RD) || (state_q == LS_RD);
    // A flush only aborts the requester that owns the current read.
    assign flush_own = (state_q == IF_RD) ? bus.if_flush : bus.lsb_flush;

`ifdef MC_IO_STALL_EN
    assign io_stall = (state_q == LS_WR) && (addr_q[17:16] == IO_HI) && bus.io_buffer_full;
`else
    logic unused_io_full;
    assign io_stall       = 1'b0;
    assign unused_io_full = bus.io_buffer_full;
`endif

    // Captured bytes with the byte arriving this cycle merged into lane cnt-1.
    always_comb begin
        cur_word = rbuf_q;
        case (cnt_q)
            3'd1:    cur_word[7:0]   = bus.mem_din;
            3'd2:    cur_word[15:8]  = bus.mem_din;
            3'd3:    cur_word[23:16] = bus.mem_din;
            3'd4:    cur_word[31:24] = bus.mem_din;
            default: cur_word        = rbuf_q;
        endcase
    end

    mc_extend u_extend (
        .word (cur_word),
        .size (size_q),
        .sign (sign_q),
        .ext  (ext_word)
    );

    // Store byte for the current cycle.
    always_comb begin
        wr_byte = 8'h00;
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    assign bus.lsb_enable = lsb_en;
    assign bus.if_done    = if_done_q;
    assign bus.if_inst    = if_inst_q;
    assign bus.data_rdy   = data_rdy_q;
    assign bus.data_read  = data_read_q;
    assign bus.mem_a      = ((rd_state && (cnt_q < nbytes_q)) || (state_q == LS_WR))
                          ? addr_q + ADDR_W'(cnt_q) : '0;
    assign bus.mem_wr     = (state_q == LS_WR) && !rdy_stall && !io_stall;
    assign bus.mem_dout   = (state_q == LS_WR) ? wr_byte : 8'h00;

    // Next-state: arbitration in IDLE, byte sequencing, flush and completion.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        nbytes_d     = nbytes_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sign_d       = sign_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        if_done_d    = 1'b0;
        if_inst_d    = if_inst_q;
        data_rdy_d   = 1'b0;
        data_read_d  = data_read_q;

        case (state_q)
            IDLE: begin
                // Only contested grants move last_grant, so the loser of one
                // tie wins the next tie regardless of uncontested traffic.
                if (lsb_go && !(if_go && last_grant_q == GNT_LSB)) begin
                    state_d  = bus.lsb_r_nw ? LS_RD : LS_WR;
                    addr_d   = bus.data_addr;
                    size_d   = bus.data_size_to_mc;
                    sign_d   = bus.load_sign;
                    wdata_d  = bus.data_write;
                    cnt_d    = 3'd0;
                    nbytes_d = size_bytes(bus.data_size_to_mc);
                    rbuf_d   = '0;
                    if (if_go) begin
                        last_grant_d = GNT_LSB;
                    end
                end else if (if_go) begin
                    state_d  = IF_RD;
                    addr_d   = bus.if_addr;
                    size_d   = SZ_W;
                    sign_d   = 1'b0;
                    cnt_d    = 3'd0;
                    nbytes_d = 3'd4;
                    rbuf_d   = '0;
                    if (lsb_go) begin
                        last_grant_d = GNT_IF;
                    end
                end
            end
            IF_RD, LS_RD: begin
                if (flush_own) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == nbytes_q) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == IF_RD) begin
                        if_done_d = 1'b1;
                        if_inst_d = cur_word;
                    end else begin
                        data_rdy_d  = 1'b1;
                        data_read_d = ext_word;
                    end
                end else begin
                    cnt_d  = 3'(cnt_q + 3'd1);
                    rbuf_d = cur_word;
                end
            end
            LS_WR: begin
                // Stores ignore lsb_flush; an I/O stall repeats the same byte.
                if (!io_stall) begin
                    if (cnt_q == 3'(nbytes_q - 3'd1)) begin
                        state_d    = IDLE;
                        cnt_d      = 3'd0;
                        data_rdy_d = 1'b1;
                    end else begin
                        cnt_d = 3'(cnt_q + 3'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register: reset wins, rdy=0 holds everything except the pulses,
    // which drop so a requester never sees a stretched completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_IF;
            cnt_q        <= 3'd0;
            nbytes_q     <= 3'd0;
            addr_q       <= '0;
            size_q       <= SZ_B;
            sign_q       <= 1'b0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            if_done_q    <= 1'b0;
            if_inst_q    <= '0;
            data_rdy_q   <= 1'b0;
            data_read_q  <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            nbytes_q     <= nbytes_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            if_done_q    <= if_done_d;
            if_inst_q    <= if_inst_d;
            data_rdy_q   <= data_rdy_d;
            data_read_q  <= data_read_d;
        end else begin
            if_done_q    <= 1'b0;
            data_rdy_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: loads, stores, arbitration, flushes, rdy stall and the I/O stall option.
// Latency: cycle k below is k cycles after the acceptance cycle A.
// Backpressure: RAM model answers one cycle after the address; io_buffer_full driven per scenario.
`timescale 1ns/1ps
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   checks = 0;
    int   errors = 0;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Preloaded read contents; writes are recorded in the log, not stored.
    logic [7:0]  ram [0:4095];
    logic [31:0] log_a [$];
    logic [7:0]  log_d [$];

    // RAM: read data one cycle after the address, log every write byte.
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[11:0]];
        if (bus.mem_wr) begin
            log_a.push_back(bus.mem_a);
            log_d.push_back(bus.mem_dout);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic lsb_start(input logic r_nw, input logic sgn, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        bus.lsb_flag        = 1'b1;
        bus.lsb_r_nw        = r_nw;
        bus.load_sign       = sgn;
        bus.data_size_to_mc = sz;
        bus.data_addr       = a;
        bus.data_write      = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b want 0", bus.if_done); end
        checks++; if (bus.data_rdy !== 1'b0) begin errors++; $display("FAIL reset_data_rdy got %b want 0", bus.data_rdy); end
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
        checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
        checks++; if (bus.if_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst got %h want 0", bus.if_inst); end
        checks++; if (bus.data_read !== 32'h0) begin errors++; $display("FAIL reset_data_read got %h want 0", bus.data_read); end
        checks++; if (bus.lsb_enable !== 1'b0) begin errors++; $display("FAIL reset_lsb_enable got %b want 0", bus.lsb_enable); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.lsb_enable !== 1'b1) begin errors++; $display("FAIL idle_lsb_enable got %b want 1", bus.lsb_enable); end
    endtask

    // Raises both requesters in one cycle and records which pulse comes first.
    task automatic run_pair(input logic [31:0] if_a, input logic [1:0] sz, input logic [31:0] ls_a,
                            output int lsb_pos, output int if_pos, output int lsb_k, output int if_k,
                            output int overlap, output logic [31:0] lsb_val, output logic [31:0] if_val);
        int seq;
        seq = 0; lsb_pos = 0; if_pos = 0; lsb_k = 0; if_k = 0; overlap = 0;
        lsb_val = '0; if_val = '0;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = if_a;
        lsb_start(1'b1, 1'b0, sz, ls_a, 32'h0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.if_done && bus.data_rdy) overlap++;
            if (bus.data_rdy) begin
                seq++; lsb_pos = seq; lsb_k = k; lsb_val = bus.data_read;
                bus.lsb_flag = 1'b0;
            end
            if (bus.if_done) begin
                seq++; if_pos = seq; if_k = k; if_val = bus.if_inst;
                bus.if_req = 1'b0;
            end
        end
        bus.lsb_flag = 1'b0;
        bus.if_req   = 1'b0;
    endtask

    task automatic test_arb();
        int lp, ip, lk, ik, ov;
        logic [31:0] lv, iv;
        // first tie after reset: LSB wins
        run_pair(32'h200, SZ_W, 32'h100, lp, ip, lk, ik, ov, lv, iv);
        checks++; if (lp !== 1) begin errors++; $display("FAIL arb1_lsb_order got %0d want 1", lp); end
        checks++; if (ip !== 2) begin errors++; $display("FAIL arb1_if_order got %0d want 2", ip); end
        checks++; if (lk !== 6) begin errors++; $display("FAIL arb1_lsb_cycle got %0d want 6", lk); end
        checks++; if (lv !== 32'h44332211) begin errors++; $display("FAIL arb1_lsb_data got %h want 44332211", lv); end
        checks++; if (iv !== 32'hDEADBEEF) begin errors++; $display("FAIL arb1_if_data got %h want deadbeef", iv); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL arb1_overlap got %0d want 0", ov); end
        // second tie: IF wins
        run_pair(32'h204, SZ_B, 32'h20, lp, ip, lk, ik, ov, lv, iv);
        checks++; if (ip !== 1) begin errors++; $display("FAIL arb2_if_order got %0d want 1", ip); end
        checks++; if (lp !== 2) begin errors++; $display("FAIL arb2_lsb_order got %0d want 2", lp); end
        checks++; if (ik !== 6) begin errors++; $display("FAIL arb2_if_cycle got %0d want 6", ik); end
        checks++; if (iv !== 32'h01020304) begin errors++; $display("FAIL arb2_if_data got %h want 01020304", iv); end
        checks++; if (lv !== 32'h00000080) begin errors++; $display("FAIL arb2_lsb_data got %h want 00000080", lv); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL arb2_overlap got %0d want 0", ov); end
    endtask

    task automatic test_lw();
        int pulses, pk;
        logic [31:0] val;
        pulses = 0; pk = 0; val = '0;
        @(negedge clk);
        lsb_start(1'b1, 1'b0, SZ_W, 32'h1000, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus.lsb_flag = 1'b0;
            #1;
            if (k == 1) begin
                checks++; if (bus.mem_a !== 32'h1000) begin errors++; $display("FAIL lw_addr0 got %h want 00001000", bus.mem_a); end
            end
            if (k == 4) begin
                checks++; if (bus.mem_a !== 32'h1003) begin errors++; $display("FAIL lw_addr3 got %h want 00001003", bus.mem_a); end
            end
            if (bus.data_rdy) begin pulses++; pk = k; val = bus.data_read; end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL lw_pulse_count got %0d want 1", pulses); end
        checks++; if (pk !== 6) begin errors++; $display("FAIL lw_pulse_cycle got %0d want 6", pk); end
        checks++; if (val !== 32'h12345678) begin errors++; $display("FAIL lw_data got %h want 12345678", val); end
    endtask

    task automatic test_lb();
        logic [31:0] addrs [3] = '{32'h20, 32'h20, 32'h22};
        logic [1:0]  szs   [3] = '{SZ_B, SZ_B, SZ_H};
        logic        sgns  [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9234};
        int          expk  [3] = '{3, 3, 4};
        for (int t = 0; t < 3; t++) begin
            int pk;
            logic [31:0] val;
            pk = 0; val = '0;
            @(negedge clk);
            lsb_start(1'b1, sgns[t], szs[t], addrs[t], 32'h0);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                bus.lsb_flag = 1'b0;
                #1;
                if (bus.data_rdy) begin pk = k; val = bus.data_read; end
            end
            checks++; if (pk !== expk[t]) begin errors++; $display("FAIL load%0d_cycle got %0d want %0d", t, pk, expk[t]); end
            checks++; if (val !== exps[t]) begin errors++; $display("FAIL load%0d_data got %h want %h", t, val, exps[t]); end
        end
    endtask

    task automatic test_sh();
        int base, pk;
        logic [31:0] ea [2] = '{32'h40, 32'h41};
        logic [7:0]  ed [2] = '{8'h34, 8'h12};
        base = log_a.size(); pk = 0;
        @(negedge clk);
        lsb_start(1'b0, 1'b0, SZ_H, 32'h40, 32'hABCD1234);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.lsb_flag = 1'b0;
            #1;
            if (bus.data_rdy) pk = k;
        end
        checks++; if (pk !== 3) begin errors++; $display("FAIL sh_pulse_cycle got %0d want 3", pk); end
        checks++; if (log_a.size() - base !== 2) begin errors++; $display("FAIL sh_byte_count got %0d want 2", log_a.size() - base); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (base + i >= log_a.size()) begin errors++; $display("FAIL sh_byte%0d got none want %h/%h", i, ea[i], ed[i]); end
            else if (log_a[base+i] !== ea[i] || log_d[base+i] !== ed[i]) begin
                errors++; $display("FAIL sh_byte%0d got %h/%h want %h/%h", i, log_a[base+i], log_d[base+i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_flush();
        int pulses, pk, base;
        logic [7:0] ed [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        // load aborted at cnt=2
        pulses = 0;
        @(negedge clk);
        lsb_start(1'b1, 1'b0, SZ_W, 32'h1000, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.lsb_flag  = 1'b0;
            bus.lsb_flush = (k == 3);
            #1;
            if (k == 4) begin
                checks++; if (bus.lsb_enable !== 1'b1) begin errors++; $display("FAIL lflush_idle got %b want 1", bus.lsb_enable); end
            end
            if (bus.data_rdy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL lflush_pulses got %0d want 0", pulses); end
        // store ignores the flush
        base = log_a.size(); pk = 0;
        @(negedge clk);
        lsb_start(1'b0, 1'b0, SZ_W, 32'h60, 32'hCAFEF00D);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.lsb_flag  = 1'b0;
            bus.lsb_flush = (k <= 4);
            #1;
            if (bus.data_rdy) pk = k;
        end
        bus.lsb_flush = 1'b0;
        checks++; if (pk !== 5) begin errors++; $display("FAIL sflush_pulse_cycle got %0d want 5", pk); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= log_a.size()) begin errors++; $display("FAIL sflush_byte%0d got none want %h", i, ed[i]); end
            else if (log_a[base+i] !== 32'h60 + 32'(i) || log_d[base+i] !== ed[i]) begin
                errors++; $display("FAIL sflush_byte%0d got %h/%h want %h/%h", i, log_a[base+i], log_d[base+i], 32'h60 + 32'(i), ed[i]);
            end
        end
        // fetch aborted at cnt=1
        pulses = 0;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) begin bus.if_flush = 1'b1; bus.if_req = 1'b0; end
            else bus.if_flush = 1'b0;
            #1;
            if (k == 3) begin
                checks++; if (bus.lsb_enable !== 1'b1) begin errors++; $display("FAIL iflush_idle got %b want 1", bus.lsb_enable); end
            end
            if (bus.if_done) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL iflush_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_rdy_stall();
        int base, pk;
        logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = log_a.size(); pk = 0;
        @(negedge clk);
        lsb_start(1'b0, 1'b0, SZ_W, 32'h80, 32'h44332211);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.lsb_flag = 1'b0;
            rdy = !(k == 2 || k == 3);
            #1;
            if (!rdy) begin
                checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL stall_mem_wr k=%0d got %b want 0", k, bus.mem_wr); end
            end
            if (bus.data_rdy) pk = k;
        end
        rdy = 1'b1;
        checks++; if (pk !== 7) begin errors++; $display("FAIL stall_pulse_cycle got %0d want 7", pk); end
        checks++; if (log_a.size() - base !== 4) begin errors++; $display("FAIL stall_byte_count got %0d want 4", log_a.size() - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= log_a.size()) begin errors++; $display("FAIL stall_byte%0d got none want %h", i, ed[i]); end
            else if (log_a[base+i] !== 32'h80 + 32'(i) || log_d[base+i] !== ed[i]) begin
                errors++; $display("FAIL stall_byte%0d got %h/%h want %h/%h", i, log_a[base+i], log_d[base+i], 32'h80 + 32'(i), ed[i]);
            end
        end
    endtask

    task automatic test_io();
        int base, pk;
        logic [6:1] wr_seen, wr_exp;
        int pk_exp;
`ifdef MC_IO_STALL_EN
        wr_exp = 6'b001000; pk_exp = 5;
`else
        wr_exp = 6'b000001; pk_exp = 2;
`endif
        base = log_a.size(); pk = 0; wr_seen = '0;
        @(negedge clk);
        lsb_start(1'b0, 1'b0, SZ_B, 32'h30000, 32'h0000005A);
        bus.io_buffer_full = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.lsb_flag       = 1'b0;
            bus.io_buffer_full = (k <= 3);
            #1;
            wr_seen[k] = bus.mem_wr;
            if (bus.data_rdy) pk = k;
        end
        bus.io_buffer_full = 1'b0;
        checks++; if (wr_seen !== wr_exp) begin errors++; $display("FAIL io_wr_pattern got %b want %b", wr_seen, wr_exp); end
        checks++; if (pk !== pk_exp) begin errors++; $display("FAIL io_pulse_cycle got %0d want %0d", pk, pk_exp); end
        checks++;
        if (log_a.size() - base !== 1) begin errors++; $display("FAIL io_byte_count got %0d want 1", log_a.size() - base); end
        else if (log_a[base] !== 32'h30000 || log_d[base] !== 8'h5A) begin
            errors++; $display("FAIL io_byte got %h/%h want 00030000/5a", log_a[base], log_d[base]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h000] = 8'h78; ram[12'h001] = 8'h56; ram[12'h002] = 8'h34; ram[12'h003] = 8'h12;
        ram[12'h020] = 8'h80; ram[12'h022] = 8'h34; ram[12'h023] = 8'h92;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h200] = 8'hEF; ram[12'h201] = 8'hBE; ram[12'h202] = 8'hAD; ram[12'h203] = 8'hDE;
        ram[12'h204] = 8'h04; ram[12'h205] = 8'h03; ram[12'h206] = 8'h02; ram[12'h207] = 8'h01;

        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.lsb_flag = 1'b0; bus.lsb_r_nw = 1'b0; bus.load_sign = 1'b0;
        bus.data_size_to_mc = 2'd0; bus.data_addr = '0; bus.data_write = '0;
        bus.lsb_flush = 1'b0; bus.io_buffer_full = 1'b0;

        test_reset();
        test_arb();
        test_lw();
        test_lb();
        test_sh();
        test_flush();
        test_rdy_stall();
        test_io();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
